// File: rtl/layer_buffer_dp.sv
// layer_buffer_dp: true dual-port feature buffer for one CNN layer.
// Port A is the producer (compute engine) and port B the consumer (next-layer fetch).
// Reads are registered with a 1-cycle VAL pulse. A same-address write on the other port
// is forwarded to the reader. On a write-write collision WR_PRIORITY picks the stored data.
// Out-of-range accesses raise a sticky ERR. An INIT-triggered sweep zeroes two entries
// per cycle.
module layer_buffer_dp #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned DEPTH       = 112,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned WR_PRIORITY = 0
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              INIT,
    output logic              BUSY,
    input  logic              CSA,
    input  logic              WEAN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] DIA,
    output logic [DATA_W-1:0] DOA,
    output logic              VALA,
    input  logic              CSB,
    input  logic              WEBN,
    input  logic [ADDR_W-1:0] B,
    input  logic [DATA_W-1:0] DIB,
    output logic [DATA_W-1:0] DOB,
    output logic              VALB,
    output logic              COLL,
    output logic              ERR
);

    // Sweep steps: each step clears a pair of entries.
    localparam int unsigned       K         = (DEPTH + 1) / 2;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(K - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] doa_q, doa_d, dob_q, dob_d;
    logic              vala_q, vala_d, valb_q, valb_d;
    logic              coll_q, coll_d, err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle, a_ok, b_ok, same;
    logic              rd_a, rd_b, wr_a, wr_b, coll;
    logic              wr_a_eff, wr_b_eff;
    logic [ADDR_W-1:0] clr_lo, clr_hi;
    logic              hi_ok;

    assign idle = (state_q == StIdle);
    assign a_ok = ({1'b0, A} < DEPTH_C);
    assign b_ok = ({1'b0, B} < DEPTH_C);
    assign same = (A == B);

    // Port accesses are only honoured in IDLE; out-of-range writes are dropped here.
    assign rd_a = idle & CSA & WEAN;
    assign rd_b = idle & CSB & WEBN;
    assign wr_a = idle & CSA & ~WEAN & a_ok;
    assign wr_b = idle & CSB & ~WEBN & b_ok;
    assign coll = wr_a & wr_b & same;

    // The losing port of a same-address write-write collision is suppressed.
    assign wr_a_eff = wr_a & ~(coll & (WR_PRIORITY != 0));
    assign wr_b_eff = wr_b & ~(coll & (WR_PRIORITY == 0));

    assign clr_lo = cnt_q << 1;
    assign clr_hi = clr_lo | ADDR_W'(1);
    assign hi_ok  = ({1'b0, clr_hi} < DEPTH_C);

    // Next-state, read-data and flag logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        doa_d   = doa_q;
        dob_d   = dob_q;
        vala_d  = 1'b0;
        valb_d  = 1'b0;
        coll_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (rd_a) begin
                    vala_d = 1'b1;
                    if (!a_ok) begin
                        doa_d = '0;
                    end else if (wr_b_eff && same) begin
                        doa_d = DIB;
                    end else begin
                        doa_d = mem[A];
                    end
                end
                if (rd_b) begin
                    valb_d = 1'b1;
                    if (!b_ok) begin
                        dob_d = '0;
                    end else if (wr_a_eff && same) begin
                        dob_d = DIA;
                    end else begin
                        dob_d = mem[B];
                    end
                end
                coll_d = coll;
                if ((CSA && !a_ok) || (CSB && !b_ok)) begin
                    err_d = 1'b1;
                end
                // An accepted INIT clears ERR even if this edge also flagged an error.
                if (INIT) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StClear: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            doa_q   <= '0;
            dob_q   <= '0;
            vala_q  <= 1'b0;
            valb_q  <= 1'b0;
            coll_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            doa_q   <= doa_d;
            dob_q   <= dob_d;
            vala_q  <= vala_d;
            valb_q  <= valb_d;
            coll_q  <= coll_d;
            err_q   <= err_d;
        end
    end

    // Storage array (not reset): sweep writes or port writes, never both in one cycle.
    always_ff @(posedge CK) begin
        if (RSTN) begin
            if (state_q == StClear) begin
                mem[clr_lo] <= '0;
                if (hi_ok) begin
                    mem[clr_hi] <= '0;
                end
            end else begin
                if (wr_a_eff) begin
                    mem[A] <= DIA;
                end
                if (wr_b_eff) begin
                    mem[B] <= DIB;
                end
            end
        end
    end

    assign BUSY = (state_q == StClear);
    assign DOA  = doa_q;
    assign DOB  = dob_q;
    assign VALA = vala_q;
    assign VALB = valb_q;
    assign COLL = coll_q;
    assign ERR  = err_q;

endmodule
